// File: rtl/keypad_scanner_pkg.sv
// Shared types and key map for the 4x4 hex keypad scanner.
// Column patterns are active-low: a 0 bit means that column is pulled down by a pressed key.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  localparam int KP_ROWS = 4;
  localparam int KP_COLS = 4;

  // Physical layout: row3 carries '*' and '#', which are reported as E and F.
  function automatic logic [3:0] kp_decode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic kp_single_low(input logic [KP_COLS-1:0] cols);
    return (cols == 4'b1110) || (cols == 4'b1101) ||
           (cols == 4'b1011) || (cols == 4'b0111);
  endfunction

  function automatic logic [1:0] kp_col_index(input logic [KP_COLS-1:0] cols);
    logic [1:0] idx;
    case (cols)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for the asynchronous keypad column lines.
// Resets to all-ones so the idle (pulled-up) keypad is seen immediately after reset.
module sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: row-at-a-time scan, press/release debounce, and a
// 32-bit digit shift register that feeds the seven-segment display controller.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int COUNT_TO         = 100_000,
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clr_in,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [31:0] val_out
);

  localparam int CW = (COUNT_TO > 1) ? $clog2(COUNT_TO + 1) : 1;
  localparam int DW = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNT_TO);
  localparam logic [DW:0]   DS_LAST  = (DW + 1)'(DEBOUNCE_SAMPLES);

  logic [3:0]    col_s;
  logic [CW-1:0] cnt_reg;
  logic          sample;

  kp_state_t     state_reg, state_next;
  logic [1:0]    row_idx_reg, row_idx_next;
  logic [1:0]    cand_row_reg, cand_row_next;
  logic [3:0]    cand_cols_reg, cand_cols_next;
  logic [DW-1:0] stable_cnt_reg, stable_cnt_next;
  logic [DW-1:0] rel_cnt_reg, rel_cnt_next;
  logic [DW:0]   stable_inc;
  logic [DW:0]   rel_inc;

  logic          accept;
  logic [3:0]    accept_code;
  logic          key_valid_reg;
  logic [3:0]    key_code_reg;
  logic [31:0]   val_reg;

  sync2 #(.WIDTH(KP_COLS)) u_col_sync (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (col_in),
    .q      (col_s)
  );

  // Dwell counter: a sample point every COUNT_TO+1 cycles.
  assign sample = (cnt_reg == CNT_LAST);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_reg <= '0;
    end else if (sample) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign stable_inc = (DW + 1)'(stable_cnt_reg) + (DW + 1)'(1);
  assign rel_inc    = (DW + 1)'(rel_cnt_reg) + (DW + 1)'(1);

  always_comb begin
    state_next      = state_reg;
    row_idx_next    = row_idx_reg;
    cand_row_next   = cand_row_reg;
    cand_cols_next  = cand_cols_reg;
    stable_cnt_next = stable_cnt_reg;
    rel_cnt_next    = rel_cnt_reg;
    accept          = 1'b0;
    accept_code     = kp_decode(cand_row_reg, kp_col_index(cand_cols_reg));

    if (sample) begin
      case (state_reg)
        SCAN: begin
          if (kp_single_low(col_s)) begin
            cand_row_next   = row_idx_reg;
            cand_cols_next  = col_s;
            stable_cnt_next = DW'(1);
            // A single required sample means the first detection already qualifies.
            if (DEBOUNCE_SAMPLES == 1) begin
              accept       = 1'b1;
              accept_code  = kp_decode(row_idx_reg, kp_col_index(col_s));
              rel_cnt_next = '0;
              state_next   = HELD;
            end else begin
              state_next = DEBOUNCE;
            end
          end else begin
            row_idx_next = row_idx_reg + 2'd1;
          end
        end

        DEBOUNCE: begin
          if (col_s == cand_cols_reg) begin
            if (stable_inc == DS_LAST) begin
              accept       = 1'b1;
              rel_cnt_next = '0;
              state_next   = HELD;
            end else begin
              stable_cnt_next = stable_inc[DW-1:0];
            end
          end else begin
            state_next   = SCAN;
            row_idx_next = row_idx_reg + 2'd1;
          end
        end

        HELD: begin
          if (col_s == 4'b1111) begin
            if (rel_inc == DS_LAST) begin
              rel_cnt_next = '0;
              state_next   = SCAN;
              row_idx_next = row_idx_reg + 2'd1;
            end else begin
              rel_cnt_next = rel_inc[DW-1:0];
            end
          end else begin
            rel_cnt_next = '0;
          end
        end

        default: begin
          state_next = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg      <= SCAN;
      row_idx_reg    <= 2'd0;
      cand_row_reg   <= 2'd0;
      cand_cols_reg  <= 4'b1111;
      stable_cnt_reg <= '0;
      rel_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      row_idx_reg    <= row_idx_next;
      cand_row_reg   <= cand_row_next;
      cand_cols_reg  <= cand_cols_next;
      stable_cnt_reg <= stable_cnt_next;
      rel_cnt_reg    <= rel_cnt_next;
    end
  end

  // Clear wins over a coincident shift; the press itself is still reported.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'h0;
      val_reg       <= 32'h0;
    end else begin
      key_valid_reg <= accept;
      if (accept) begin
        key_code_reg <= accept_code;
      end
      if (clr_in) begin
        val_reg <= 32'h0;
      end else if (accept) begin
        val_reg <= {val_reg[27:0], accept_code};
      end
    end
  end

  for (genvar gi = 0; gi < KP_ROWS; gi++) begin : g_row_drive
    assign row_out[gi] = (row_idx_reg != 2'(gi));
  end

  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign key_held  = (state_reg == HELD);
  assign val_out   = val_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with COUNT_TO=4, DEBOUNCE_SAMPLES=2 and a
// behavioural key matrix model driving col_in from row_out.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_in;
  logic        clr_in;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [31:0] val_out;

  logic [15:0] pressed;
  logic [3:0]  glitch;

  int checks;
  int failures;
  int pulses;
  int base;

  keypad_scanner #(
    .COUNT_TO         (4),
    .DEBOUNCE_SAMPLES (2)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .clr_in    (clr_in),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .val_out   (val_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A pressed key pulls its column low only while its row is driven low.
  always_comb begin
    col_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
      end
    end
    col_in = col_in & ~glitch;
  end

  initial pulses = 0;
  always @(negedge clk) if (key_valid) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the first negedge after row_out switches to r.
  task automatic wait_fresh_row(input string tag, input logic [3:0] r);
    int b;
    b = 0;
    while (row_out == r && b < 100) begin
      @(negedge clk);
      b++;
    end
    while (row_out != r && b < 100) begin
      @(negedge clk);
      b++;
    end
    check(tag, row_out, r);
  endtask

  task automatic press_release(input int r, input int c, input int hold, input int rel);
    pressed[r*4+c] = 1'b1;
    cycles(hold);
    pressed = '0;
    cycles(rel);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    pressed  = '0;
    glitch   = '0;
    clr_in   = 1'b0;
    rst_in   = 1'b1;
    cycles(3);
    rst_in = 1'b0;

    check("rst_row_out", row_out, 4'b1110);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_code", key_code, 0);
    check("rst_key_held", key_held, 0);
    check("rst_val_out", val_out, 0);

    // Single press of key 5 (row1/col1)
    base = pulses;
    pressed[1*4+1] = 1'b1;
    cycles(200);
    check("k5_held_down", key_held, 1);
    pressed = '0;
    cycles(2);
    check("k5_held_just_released", key_held, 1);
    cycles(60);
    check("k5_held_after_release", key_held, 0);
    check("k5_pulse_count", pulses - base, 1);
    check("k5_code", key_code, 4'h5);
    check("k5_val", val_out, 32'h5);

    // Clear while idle, then enter 1 2 A D
    clr_in = 1'b1;
    cycles(1);
    clr_in = 1'b0;
    check("clr_idle_val", val_out, 0);
    check("clr_idle_code", key_code, 4'h5);
    base = pulses;
    press_release(0, 0, 100, 60);
    press_release(0, 1, 100, 60);
    press_release(0, 3, 100, 60);
    press_release(3, 3, 100, 60);
    check("seq_val_12AD", val_out, 32'h12AD);
    check("seq_code_D", key_code, 4'hD);

    // Nine presses of 0 push every earlier digit out
    for (int i = 0; i < 5; i++) press_release(3, 1, 100, 60);
    check("zeros5_val", val_out, 32'h2AD0_0000);
    for (int i = 0; i < 4; i++) press_release(3, 1, 100, 60);
    check("zeros9_val", val_out, 32'h0);
    check("zeros9_code", key_code, 4'h0);
    check("seq_pulse_count", pulses - base, 13);

    // One-sample glitch on col2 while row3 is driven
    base = pulses;
    wait_fresh_row("glitch_sync", 4'b0111);
    glitch = 4'b0100;
    cycles(4);
    glitch = 4'b0000;
    cycles(8);
    check("glitch_row_a", row_out, 4'b1110);
    cycles(5);
    check("glitch_row_b", row_out, 4'b1101);
    cycles(5);
    check("glitch_row_c", row_out, 4'b1011);
    cycles(5);
    check("glitch_row_d", row_out, 4'b0111);
    cycles(5);
    check("glitch_row_e", row_out, 4'b1110);
    check("glitch_no_pulse", pulses - base, 0);
    check("glitch_not_held", key_held, 0);

    // Two columns low on row0
    base = pulses;
    wait_fresh_row("twocol_sync", 4'b1110);
    pressed[0*4+0] = 1'b1;
    pressed[0*4+2] = 1'b1;
    cycles(7);
    check("twocol_row_advance", row_out, 4'b1101);
    cycles(40);
    check("twocol_no_pulse", pulses - base, 0);
    check("twocol_not_held", key_held, 0);
    pressed = '0;
    cycles(10);

    // Load a digit, then reset while key 5 is in debounce
    press_release(3, 2, 100, 60);
    check("kF_code", key_code, 4'hF);
    check("kF_val", val_out, 32'hF);
    wait_fresh_row("rst_sync", 4'b1101);
    pressed[1*4+1] = 1'b1;
    cycles(7);
    base = pulses;
    rst_in = 1'b1;
    cycles(1);
    rst_in = 1'b0;
    check("mid_rst_row_out", row_out, 4'b1110);
    check("mid_rst_key_valid", key_valid, 0);
    check("mid_rst_key_code", key_code, 0);
    check("mid_rst_key_held", key_held, 0);
    check("mid_rst_val_out", val_out, 0);
    cycles(9);
    check("mid_rst_no_pulse", pulses - base, 0);
    check("mid_rst_not_held", key_held, 0);
    cycles(20);
    check("mid_rst_revisit_pulse", pulses - base, 1);
    check("mid_rst_revisit_code", key_code, 4'h5);
    check("mid_rst_revisit_val", val_out, 32'h5);
    pressed = '0;
    cycles(60);

    // clr_in coincident with the accepting sample of an F press
    base = pulses;
    wait_fresh_row("clrF_sync", 4'b0111);
    pressed[3*4+2] = 1'b1;
    cycles(9);
    clr_in = 1'b1;
    cycles(1);
    clr_in = 1'b0;
    check("clrF_key_valid", key_valid, 1);
    check("clrF_key_code", key_code, 4'hF);
    check("clrF_val", val_out, 32'h0);
    cycles(1);
    check("clrF_pulse_one_cycle", key_valid, 0);
    pressed = '0;
    cycles(60);
    check("clrF_val_after", val_out, 32'h0);
    check("clrF_pulse_count", pulses - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
